// File: rtl/csdf_expand_if.sv
// Handshake bundles for csdf_expand: the popping side of the input FIFO and the
// per-flux, per-port output FIFO bank. "master" is the expander's view of each.
interface csdf_read_if #(
  parameter int WIDTH = 9
);
  logic             empty;
  logic [WIDTH-1:0] dout;
  logic             read;

  modport master (input empty, input dout, output read);
  modport slave  (output empty, output dout, input read);
endinterface

interface csdf_write_if #(
  parameter int WIDTH = 9,
  parameter int PORTS = 2,
  parameter int FLUX  = 2
);
  logic [FLUX*PORTS-1:0]  full;
  logic [WIDTH*PORTS-1:0] din;
  logic [FLUX*PORTS-1:0]  write;

  modport master (input full, output din, output write);
  modport slave  (output full, input din, input write);
endinterface

// File: rtl/csdf_expand.sv
// Tagged-token expander: pops {tag,data} and replays it NUM_OP times onto every port
// of the tagged flux. Define CSDF_EXPAND_BYPASS_EN to pop the next token on the last replay.
package csdf_expand_pkg;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;
endpackage

module csdf_expand #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int NUM_OP     = 4
) (
  input  logic          clk,
  input  logic          rst,
  csdf_read_if.master   read_port,
  csdf_write_if.master  write_port
);
  import csdf_expand_pkg::*;

  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int CNT_W     = ($clog2(NUM_OP) > 1) ? $clog2(NUM_OP) : 1;
  localparam int NUM_EFF   = (NUM_OP == 0) ? 1 : NUM_OP;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_EFF - 1);

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [TAG_WIDTH-1:0]    head_tag;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_ok;
  logic                    go;
  logic                    read_o;
  logic [FLUX*PORTS-1:0]   write_o;

  assign {head_tag, head_data} = read_port.dout;
  // Tags past the last flux are consumed and discarded rather than stalling the input.
  assign head_ok = (int'(head_tag) < FLUX);

  // A flux may only fire when every one of its ports has room, so replays stay atomic.
  always_comb begin
    go = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      if (tag_q == TAG_WIDTH'(f)) go = ~|write_port.full[f*PORTS +: PORTS];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    read_o  = 1'b0;
    write_o = '0;
    case (state_q)
      IDLE: begin
        read_o = !read_port.empty;
        if (!read_port.empty && head_ok) begin
          tag_d   = head_tag;
          data_d  = head_data;
          cnt_d   = CNT_LAST;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (go) begin
          for (int f = 0; f < FLUX; f++) begin
            if (tag_q == TAG_WIDTH'(f)) write_o[f*PORTS +: PORTS] = '1;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d   = CNT_LAST;
            state_d = IDLE;
`ifdef CSDF_EXPAND_BYPASS_EN
            read_o = !read_port.empty;
            if (!read_port.empty && head_ok) begin
              tag_d   = head_tag;
              data_d  = head_data;
              state_d = EMIT;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are combinational and forced quiet while reset is held.
  assign read_port.read   = rst ? 1'b0 : read_o;
  assign write_port.write = rst ? '0 : write_o;
  assign write_port.din   = rst ? '0 : {PORTS{tag_q, data_q}};

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the token registers are reset too because they drive din directly.
      tag_q   <= '0;
      data_q  <= '0;
      cnt_q   <= CNT_LAST;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_csdf_expand.sv
// Scoreboard bench for csdf_expand: a FIFO model feeds tokens, a negedge monitor
// pops expected {mask,din} pairs per write; a FLUX=3, NUM_OP=0 instance is checked directly.
module tb_csdf_expand;
  import csdf_expand_pkg::*;

  localparam int DW = 8, FLUX = 2, PORTS = 2, NUM_OP = 4, W = 9;

  typedef struct packed {
    logic [3:0]  mask;
    logic [17:0] din;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csdf_read_if  #(.WIDTH(W)) rd_if ();
  csdf_write_if #(.WIDTH(W), .PORTS(PORTS), .FLUX(FLUX)) wr_if ();
  csdf_read_if  #(.WIDTH(10)) rd3 ();
  csdf_write_if #(.WIDTH(10), .PORTS(2), .FLUX(3)) wr3 ();

  csdf_expand #(.DATA_WIDTH(DW), .FLUX(FLUX), .PORTS(PORTS), .NUM_OP(NUM_OP)) dut (
    .clk(clk), .rst(rst), .read_port(rd_if), .write_port(wr_if)
  );

  csdf_expand #(.DATA_WIDTH(8), .FLUX(3), .PORTS(2), .NUM_OP(0)) u3 (
    .clk(clk), .rst(rst), .read_port(rd3), .write_port(wr3)
  );

  exp_t       exp_q[$];
  logic [8:0] in_q[$];
  int         wr_cyc[$];
  int         rd_cyc[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         pop_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tok(input logic tag, input logic [7:0] data);
    exp_t e;
    in_q.push_back({tag, data});
    e.mask = tag ? 4'b1100 : 4'b0011;
    e.din  = {tag, data, tag, data};
    repeat (NUM_OP) exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic wait_writes(input int k, input int budget);
    int n = 0;
    while (wr_cyc.size() < k && n < budget) begin
      tick();
      n++;
    end
    check("wait_writes", wr_cyc.size(), k);
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    rd_cyc.delete();
  endtask

  // Input FIFO model: pops after the edge that consumed the head, then refreshes the head.
  initial begin
    rd_if.empty = 1'b1;
    rd_if.dout  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending) void'(in_q.pop_front());
      #1;
      rd_if.empty = (in_q.size() == 0);
      rd_if.dout  = (in_q.size() != 0) ? in_q[0] : '0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      pop_pending = rd_if.read;
      if (rst) begin
        check("rst_read", rd_if.read, 0);
        check("rst_write", wr_if.write, 0);
        check("rst_din", wr_if.din, 0);
      end else begin
        if (rd_if.read) rd_cyc.push_back(cyc);
        if (wr_if.write != '0) begin
          wr_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_write", wr_if.write, 0);
          end else begin
            e = exp_q.pop_front();
            check("write_mask", wr_if.write, e.mask);
            check("din", wr_if.din, e.din);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    wr_if.full = '0;
    wr3.full   = '0;
    rd3.empty  = 1'b1;
    rd3.dout   = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_state", dut.state_q, IDLE);
    check("reset_cnt", dut.cnt_q, 3);
    check("reset_tag", dut.tag_q, 0);
    check("reset_data", dut.data_q, 0);
    check("reset_u3_state", u3.state_q, IDLE);
    rst = 1'b0;
    tick();

    // 1: single token, outputs free.
    clear_log();
    push_tok(1'b1, 8'h5A);
    wait_done(40);
    check("t1_reads", rd_cyc.size(), 1);
    check("t1_writes", wr_cyc.size(), 4);
    check("t1_latency", wr_cyc[0] - rd_cyc[0], 1);
    check("t1_consecutive", wr_cyc[3] - wr_cyc[0], 3);
    check("t1_idle", dut.state_q, IDLE);

    // 2: port 1 of flux 0 full during EMIT cycles 2-4.
    tick();
    clear_log();
    push_tok(1'b0, 8'h11);
    wait_writes(1, 20);
    wr_if.full = 4'b0010;
    repeat (3) tick();
    wr_if.full = 4'b0000;
    wait_done(40);
    check("t2_writes", wr_cyc.size(), 4);
    check("t2_stall_gap", wr_cyc[1] - wr_cyc[0], 4);
    check("t2_last", wr_cyc[3] - wr_cyc[0], 6);

    // 3: the other flux is full; flux 0 must run unaffected.
    tick();
    clear_log();
    wr_if.full = 4'b1100;
    push_tok(1'b0, 8'h33);
    wait_done(40);
    wr_if.full = 4'b0000;
    check("t3_writes", wr_cyc.size(), 4);
    check("t3_consecutive", wr_cyc[3] - wr_cyc[0], 3);

    // 4: back-to-back tokens.
    tick();
    clear_log();
    push_tok(1'b1, 8'hFF);
    push_tok(1'b0, 8'h01);
    wait_done(60);
    check("t4_writes", wr_cyc.size(), 8);
    check("t4_reads", rd_cyc.size(), 2);
`ifdef CSDF_EXPAND_BYPASS_EN
    check("t4_span", wr_cyc[7] - rd_cyc[0] + 1, 9);
    check("t4_second_pop", rd_cyc[1] - wr_cyc[3], 0);
`else
    check("t4_span", wr_cyc[7] - rd_cyc[0] + 1, 10);
    check("t4_second_pop", rd_cyc[1] - wr_cyc[3], 1);
`endif

    // 5: reset after the second write of a token.
    tick();
    clear_log();
    push_tok(1'b0, 8'hC3);
    wait_writes(2, 20);
    rst = 1'b1;
    exp_q.delete();
    push_tok(1'b1, 8'h3C);
    repeat (3) tick();
    rst = 1'b0;
    check("t5_state", dut.state_q, IDLE);
    check("t5_cnt", dut.cnt_q, 3);
    clear_log();
    wait_done(40);
    check("t5_writes", wr_cyc.size(), 4);

    // 6: FLUX=3, NUM_OP=0 instance; tag 3 is dropped, tag 2 writes once.
    tick();
    rd3.dout  = {2'd3, 8'hAB};
    rd3.empty = 1'b0;
    @(negedge clk);
    check("t6_bad_read", rd3.read, 1);
    check("t6_bad_nowrite", wr3.write, 0);
    tick();
    rd3.dout = {2'd2, 8'h42};
    @(negedge clk);
    check("t6_dropped_idle", u3.state_q, IDLE);
    check("t6_good_read", rd3.read, 1);
    check("t6_good_nowrite", wr3.write, 0);
    tick();
    rd3.empty = 1'b1;
    rd3.dout  = '0;
    @(negedge clk);
    check("t6_write", wr3.write, 6'b110000);
    check("t6_din", wr3.din, {10'h242, 10'h242});
    tick();
    @(negedge clk);
    check("t6_single", wr3.write, 0);
    check("t6_back_idle", u3.state_q, IDLE);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
